// File: rtl/ffjk_bank_sequencer.sv
// Command sequencer driving per-bit J/K vectors into a bank of JK flip-flops,
// tracking a shadow of the bank value. Define FFJK_SEQ_CHECK_EN to add the iQ/shadow check and oErr.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_IDLE  | ready for a command, J=K=0 so the bank holds
// ST_DRIVE | J/K pattern applied each cycle until the step counter expires
// ST_DONE  | one-cycle completion pulse, J=K=0
module ffjk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iCmdValid,
    output logic             oCmdReady,
    input  logic [2:0]       iCmd,
    input  logic [WIDTH-1:0] iData,
    input  logic [CNT_W-1:0] iSteps,
    output logic [WIDTH-1:0] oJ,
    output logic [WIDTH-1:0] oK,
    input  logic [WIDTH-1:0] iQ,
    output logic [WIDTH-1:0] oShadow,
    output logic             oBusy,
`ifdef FFJK_SEQ_CHECK_EN
    output logic             oDone,
    output logic             oErr
`else
    output logic             oDone
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shadow, w_shadow_nxt, w_shadow_upd;
    logic [WIDTH-1:0] r_j, r_k, w_j_nxt, w_k_nxt;
    logic [CNT_W-1:0] w_steps;

    // Returns {J, K}; shadow is the value the bank holds when the pattern is sampled.
    function automatic logic [2*WIDTH-1:0] f_pattern(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] data,
        input logic [WIDTH-1:0] shadow
    );
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
        logic             carry;
        j     = '0;
        k     = '0;
        carry = 1'b1;
        case (op)
            OP_CLEAR:  k = '1;
            OP_SET:    j = '1;
            OP_TOGGLE: begin
                j = '1;
                k = '1;
            end
            OP_LOAD: begin
                j = data;
                k = ~data;
            end
            OP_CNT_UP, OP_CNT_DN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    j[i]  = carry;
                    k[i]  = carry;
                    carry = carry & ((op == OP_CNT_UP) ? shadow[i] : ~shadow[i]);
                end
            end
            default: ;
        endcase
        return {j, k};
    endfunction

    assign w_shadow_upd = (r_j & ~r_shadow) | (~r_k & r_shadow);
    assign w_steps      = ((iCmd == OP_CNT_UP) || (iCmd == OP_CNT_DN)) ? iSteps : CNT_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_data_nxt   = r_data;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_j_nxt      = '0;
        w_k_nxt      = '0;
        case (r_state)
            ST_IDLE: begin
                if (iCmdValid) begin
                    w_op_nxt   = iCmd;
                    w_data_nxt = iData;
                    w_cnt_nxt  = w_steps;
                    if (w_steps == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt        = ST_DRIVE;
                        {w_j_nxt, w_k_nxt} = f_pattern(iCmd, iData, r_shadow);
                    end
                end
            end
            ST_DRIVE: begin
                w_shadow_nxt = w_shadow_upd;
                w_cnt_nxt    = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    {w_j_nxt, w_k_nxt} = f_pattern(r_op, r_data, w_shadow_upd);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_j      <= '0;
            r_k      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_data   <= w_data_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
        end
    end

    assign oCmdReady = (r_state == ST_IDLE);
    assign oBusy     = (r_state != ST_IDLE);
    assign oDone     = (r_state == ST_DONE);
    assign oJ        = r_j;
    assign oK        = r_k;
    assign oShadow   = r_shadow;

`ifdef FFJK_SEQ_CHECK_EN
    logic r_err;

    // The last bank update landed at the edge entering DONE, so iQ is settled here.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_DONE) && (iQ != r_shadow)) begin
            r_err <= 1'b1;
        end
    end

    assign oErr = r_err;
`else
    logic w_unused_q;
    assign w_unused_q = ^iQ;
`endif

endmodule
